uart_fifoed_recv: RTL and testbench
===================================

// Module: uart_fifoed_recv
// PURPOSE
//   UART receiver, 8N1, LSB first, for the 100 MHz system clock. Oversamples the
//   asynchronous RX line, centre-samples each bit and pushes each good byte into
//   an 8-entry show-ahead FIFO drained by the core. Receive-side counterpart of
//   the FIFO-buffered UART transmitter; same baud (868 clk/bit = 115200 Bd).
// PARAMETERS
//   CLKS_PER_BIT  868  clock cycles per UART bit period
//   FIFO_DEPTH    8    FIFO entries (power of two)
//   FIFO_AW       3    log2(FIFO_DEPTH), pointer width
// PORTS
//   clk_100MHz  in   1  system clock, all logic on rising edge
//   reset       in   1  synchronous, active-high
//   RX          in   1  asynchronous serial input, idle high
//   rd_en       in   1  pop head byte (ignored when fifo_empty=1)
//   dat         out  8  FIFO head byte; 8'h00 when fifo_empty=1
//   fifo_empty  out  1  no byte available
//   fifo_afull  out  1  n_elements >= FIFO_DEPTH-2
//   fifo_full   out  1  n_elements == FIFO_DEPTH
//   busy        out  1  receive FSM not in IDLE
//   frame_err   out  1  1-cycle pulse: stop bit sampled low
//   overrun     out  1  1-cycle pulse: good byte dropped, FIFO full
// BEHAVIOUR
//   Reset: FSM=IDLE, pointers/count=0, fifo_empty=1, fifo_full=0, fifo_afull=0,
//     busy=0, frame_err=0, overrun=0, dat=8'h00, synchroniser regs=1. FIFO RAM not cleared.
//   Input: RX through 2-FF synchroniser (rx_s), 2-cycle delay; nothing else reads RX.
//   Bit timer cnt (12 b), reloaded on state entry, decrements to 0; "tick" = cnt==0.
//   FSM (5 states):
//     IDLE:  rx_s==0 -> START, cnt=CLKS_PER_BIT/2-1.
//     START: tick & rx_s==0 -> DATA, cnt=CLKS_PER_BIT-1, bit_idx=0;
//            tick & rx_s==1 -> IDLE (glitch rejected, no flags).
//     DATA:  tick -> shift={rx_s,shift[7:1]}, bit_idx++, cnt reload; after 8th
//            sample -> STOP, cnt=CLKS_PER_BIT-1.
//     STOP:  tick & rx_s==1 -> push request, -> IDLE;
//            tick & rx_s==0 -> frame_err pulse, no push, -> BREAK.
//     BREAK: wait rx_s==1 -> IDLE (line held low never restarts a frame).
//   Push: registered; byte written at edge after stop sample; fifo_empty falls and
//     dat valid in the following cycle. Total RX-stop-centre to visible ~3 cycles.
//   Push when full: byte dropped, overrun pulse, FIFO unchanged -- except if rd_en=1
//     in the same cycle: pop and push both occur, count stays FIFO_DEPTH, no overrun.
//   Pop: rd_en & !fifo_empty -> rd_ptr++ at edge; dat shows next entry next cycle.
//   Simultaneous push+pop (not empty): count unchanged, both pointers advance.
//   Push into empty with rd_en=1: rd_en ignored (empty), byte stored.
//   Pointers FIFO_AW bits, wrap naturally DEPTH-1 -> 0; count FIFO_AW+1 bits.
//   frame_err/overrun never both in one cycle; both are single-cycle, non-sticky.
//   Reset mid-frame: partial byte discarded, FIFO flushed, FSM IDLE next cycle;
//     if RX still low after reset a new START is entered (glitch check applies).
// TESTING
//   1. Send 0x55 then 0xA3 at 868 clk/bit -> dat=0x55, fifo_empty=0; rd_en -> dat=0xA3;
//      rd_en -> fifo_empty=1, dat=0x00; no flags.
//   2. Send 8 bytes 0x00..0x07, no reads -> fifo_afull after 6th, fifo_full after 8th;
//      9th byte 0xFF -> overrun 1 cycle, contents 0x00..0x07 read back in order.
//   3. Full FIFO, assert rd_en exactly in push cycle of 9th byte 0x42 -> no overrun,
//      read order 0x01..0x07,0x42 (wrap across pointer 7->0 checked).
//   4. Frame 0x3C with stop bit low, RX held low 5000 cycles -> frame_err once,
//      nothing pushed, busy=1 until RX high, then next byte 0x81 received correctly.
//   5. RX low pulse 300 cycles -> START rejected, busy returns 0, FIFO empty, no flags.
//   6. Reset asserted at data bit 4 of 0x96 with 3 bytes queued -> fifo_empty=1,
//      busy=0 after reset; next full frame 0x5A received; baud +/-2% still error-free.

Source files
------------

// File: rtl/uart_fifoed_recv.sv
// 8N1 UART receiver with centre sampling, feeding
// an 8-entry show-ahead FIFO drained by the core.
module uart_fifoed_recv #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8,
  parameter int FIFO_AW      = 3
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       RX,
  input  logic       rd_en,
  output logic [7:0] dat,
  output logic       fifo_empty,
  output logic       fifo_afull,
  output logic       fifo_full,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  localparam logic [11:0] HALF = 12'(CLKS_PER_BIT / 2 - 1);
  localparam logic [11:0] FULL = 12'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW + 1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW:0] AFULL = (FIFO_AW + 1)'(FIFO_DEPTH - 2);

  logic               r_rx_m;
  logic               r_rx_s;
  state_t             r_state;
  state_t             w_state_nx;
  logic [11:0]        r_cnt;
  logic [11:0]        w_cnt_nx;
  logic [2:0]         r_bit_idx;
  logic [2:0]         w_bit_idx_nx;
  logic [7:0]         r_shift;
  logic [7:0]         w_shift_nx;
  logic               r_push;
  logic               w_push_nx;
  logic               r_frame_err;
  logic               w_frame_err_nx;
  logic               r_overrun;
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic               w_tick;
  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_wr;

  // RX is asynchronous; only r_rx_s is used downstream.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      r_rx_m <= 1'b1;
      r_rx_s <= 1'b1;
    end else begin
      r_rx_m <= RX;
      r_rx_s <= r_rx_m;
    end
  end

  assign w_tick = (r_cnt == 12'd0);

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 12'd0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'h00;
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_bit_idx   <= w_bit_idx_nx;
      r_shift     <= w_shift_nx;
      r_push      <= w_push_nx;
      r_frame_err <= w_frame_err_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = w_tick ? r_cnt : r_cnt - 12'd1;
    w_bit_idx_nx   = r_bit_idx;
    w_shift_nx     = r_shift;
    w_push_nx      = 1'b0;
    w_frame_err_nx = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!r_rx_s) begin
          w_state_nx = S_START;
          w_cnt_nx   = HALF;
        end
      end
      S_START: begin
        if (w_tick) begin
          if (!r_rx_s) begin
            w_state_nx   = S_DATA;
            w_cnt_nx     = FULL;
            w_bit_idx_nx = 3'd0;
          end else begin
            w_state_nx = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_shift_nx   = {r_rx_s, r_shift[7:1]};
          w_bit_idx_nx = r_bit_idx + 3'd1;
          w_cnt_nx     = FULL;
          if (r_bit_idx == 3'd7) w_state_nx = S_STOP;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (r_rx_s) begin
            w_push_nx  = 1'b1;
            w_state_nx = S_IDLE;
          end else begin
            w_frame_err_nx = 1'b1;
            w_state_nx     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (r_rx_s) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DEPTH);
  assign w_pop   = rd_en & ~w_empty;
  // A pop in the push cycle frees the slot the push needs.
  assign w_wr    = r_push & (~w_full | w_pop);

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr && !w_pop) r_count <= r_count + 1'b1;
      else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
      r_overrun <= r_push & w_full & ~w_pop;
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_shift;
  end

  assign dat        = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign fifo_empty = w_empty;
  assign fifo_full  = w_full;
  assign fifo_afull = (r_count >= AFULL);
  assign busy       = (r_state != S_IDLE);
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_fifoed_recv.sv
// Bench for uart_fifoed_recv: serial frames in,
// FIFO contents and flags checked against a queue model.
module tb_uart_fifoed_recv;

  localparam int CPB = 100;

  logic       clk;
  logic       reset;
  logic       RX;
  logic       rd_en;
  logic [7:0] dat;
  logic       fifo_empty;
  logic       fifo_afull;
  logic       fifo_full;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int n_fe = 0;
  int n_ov = 0;
  int n_both = 0;
  int fe_exp = 0;
  int ov_exp = 0;
  logic [7:0] q[$];

  uart_fifoed_recv #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(8),
    .FIFO_AW(3)
  ) dut (
    .clk_100MHz(clk),
    .reset(reset),
    .RX(RX),
    .rd_en(rd_en),
    .dat(dat),
    .fifo_empty(fifo_empty),
    .fifo_afull(fifo_afull),
    .fifo_full(fifo_full),
    .busy(busy),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles-high counters: a stuck flag over-counts.
  always @(negedge clk) begin
    if (frame_err === 1'b1) n_fe++;
    if (overrun === 1'b1) n_ov++;
    if (frame_err === 1'b1 && overrun === 1'b1) n_both++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    logic [7:0] hd;
    hd = (q.size() > 0) ? q[0] : 8'h00;
    chk({tag, "_dat"}, 32'(dat), 32'(hd));
    chk({tag, "_empty"}, 32'(fifo_empty), 32'(q.size() == 0));
    chk({tag, "_afull"}, 32'(fifo_afull), 32'(q.size() >= 6));
    chk({tag, "_full"}, 32'(fifo_full), 32'(q.size() == 8));
    chk({tag, "_fe"}, 32'(n_fe), 32'(fe_exp));
    chk({tag, "_ov"}, 32'(n_ov), 32'(ov_exp));
    chk({tag, "_both"}, 32'(n_both), 32'd0);
  endtask

  // pop_at: frame cycle whose following edge sees rd_en=1.
  // rst_at: frame cycle at which reset pulses and the frame aborts.
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int cpb, input int pop_at,
                            input int rst_at);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int k = 0; k < 10 * cpb; k++) begin
      @(negedge clk);
      if (k == rst_at) begin
        reset = 1'b1;
        rd_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        RX = 1'b1;
        return;
      end
      RX = fr[k / cpb];
      rd_en = (k == pop_at);
    end
    rd_en = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b, input int cpb,
                         input int pop_at);
    send_frame(b, 1'b1, cpb, pop_at, -1);
    if (pop_at >= 0 && q.size() > 0) void'(q.pop_front());
    if (q.size() < 8) q.push_back(b);
    else ov_exp++;
  endtask

  task automatic pop_one();
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic idle(input logic v, input int n);
    repeat (n) begin
      @(negedge clk);
      RX = v;
    end
  endtask

  // Edge of the FIFO write, counted from the start-bit edge.
  localparam int PUSH_K = CPB / 2 + 3 + 9 * CPB;

  initial begin
    logic [7:0] b;
    int cpb;
    reset = 1'b1;
    RX    = 1'b1;
    rd_en = 1'b0;
    repeat (3) @(negedge clk);
    chk_state("reset");
    chk("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    idle(1'b1, 5);

    // two bytes, show-ahead head, drain to empty
    rx_byte(8'h55, CPB, -1);
    chk_state("t1_b0");
    rx_byte(8'hA3, CPB, -1);
    chk_state("t1_b1");
    chk("t1_busy", 32'(busy), 32'd0);
    pop_one();
    chk_state("t1_pop0");
    pop_one();
    chk_state("t1_pop1");

    // fill, afull/full thresholds, overrun on 9th
    for (int i = 0; i < 8; i++) begin
      rx_byte(8'(i), CPB, -1);
      chk_state($sformatf("t2_fill%0d", i));
    end
    rx_byte(8'hFF, CPB, -1);
    chk_state("t2_over");

    // pop in the push cycle of a full FIFO: no overrun, wraps
    rx_byte(8'h42, CPB, PUSH_K);
    chk_state("t3_swap");
    for (int i = 0; i < 8; i++) begin
      pop_one();
      chk_state($sformatf("t3_rd%0d", i));
    end

    // low stop bit then long break
    send_frame(8'h3C, 1'b0, CPB, -1, -1);
    fe_exp++;
    idle(1'b0, 5000);
    chk("t4_busy_brk", 32'(busy), 32'd1);
    chk_state("t4_brk");
    idle(1'b1, 10);
    chk("t4_busy_idle", 32'(busy), 32'd0);
    rx_byte(8'h81, CPB, -1);
    chk_state("t4_next");
    pop_one();

    // short low glitch is rejected
    idle(1'b0, 10);
    chk("t5_busy_start", 32'(busy), 32'd1);
    idle(1'b0, CPB / 3 - 10);
    idle(1'b1, 2 * CPB);
    chk("t5_busy", 32'(busy), 32'd0);
    chk_state("t5_glitch");

    // rd_en while empty during the push is ignored
    rx_byte(8'hC7, CPB, PUSH_K);
    chk_state("t5_empty_pop");
    pop_one();

    // reset mid-frame flushes queued bytes
    for (int i = 0; i < 3; i++) rx_byte(8'($urandom), CPB, -1);
    chk_state("t6_queued");
    send_frame(8'h96, 1'b1, CPB, -1, 5 * CPB + 40);
    q.delete();
    chk_state("t6_reset");
    chk("t6_busy", 32'(busy), 32'd0);
    idle(1'b1, 5);
    rx_byte(8'h5A, CPB, -1);
    chk_state("t6_5a");
    rx_byte(8'($urandom), CPB - 2, -1);
    chk_state("t6_fast");
    rx_byte(8'($urandom), CPB + 2, -1);
    chk_state("t6_slow");

    // random bytes, baud within +/-2%, random pops
    for (int i = 0; i < 10; i++) begin
      b   = 8'($urandom);
      cpb = CPB - 2 + int'($urandom_range(0, 4));
      rx_byte(b, cpb, -1);
      chk_state($sformatf("rnd%0d", i));
      if ($urandom_range(0, 2) == 0) begin
        pop_one();
        chk_state($sformatf("rnd_pop%0d", i));
      end
    end
    for (int i = 0; i < 9; i++) begin
      pop_one();
      chk_state($sformatf("drain%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
